key_conditioner: RTL and testbench

- Conditions the raw active-low DE10 push-buttons before they reach the stopwatch controller.
- Per key, it performs 2-FF synchronisation, a debounce state machine, single-cycle press and release pulses, a debounced level, and a long-press pulse.
- It sits directly upstream of the stopwatch top level. key_press[0] drives start/stop, key_press[1] drives lap, and key_long[1] drives lap clear.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/key_debounce.sv | 137 +++++++++++++
 rtl/key_conditioner.sv | 49 ++++
 tb/tb_key_conditioner.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_pkg
// Purpose : Shared types and helpers for the stopwatch key path.
//           - key_state_t : per-key debounce FSM state encoding
//           - ms_to_cycles: converts a millisecond interval to clock cycles
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Integer milliseconds to cycles at clk_hz; truncates any fraction.
    function automatic int unsigned ms_to_cycles(input longint unsigned clk_hz,
                                                 input int unsigned     ms);
        longint unsigned w_cycles;
        w_cycles = (clk_hz * 64'(ms)) / 64'd1000;
        return w_cycles[31:0];
    endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce
// Purpose : Conditions one raw active-low push-button: 2-FF synchroniser,
//           debounce FSM, press/release/long-press pulses and debounced level.
// Ports   : clk         in  system clock
//           reset       in  synchronous active-high reset
//           key_n       in  raw asynchronous button, 0 = pressed
//           key_level   out 1 while debounced-pressed (PRESSED/RELEASE_WAIT)
//           key_press   out 1-cycle pulse on a debounced press
//           key_release out 1-cycle pulse on a debounced release
//           key_long    out 1-cycle pulse once per press at the long-hold mark
// Revision: 1.0 - initial release
// ============================================================================
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_PRE  = c_HOLD_W'(LONG_PRESS_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
        end
        if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
            $error("key_debounce: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
        end
    endgenerate

    logic                r_sync1;
    logic                r_sync2;
    key_state_t          r_state;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                w_sync_pressed;

    assign w_sync_pressed = ~r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchroniser resets to "released" so a held key is re-detected
            // cleanly once reset drops.
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            r_sync1     <= key_n;
            r_sync2     <= r_sync1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_sync_pressed) begin
                        r_state  <= PRESS_WAIT;
                        r_db_cnt <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!w_sync_pressed) begin
                        r_state  <= IDLE;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state    <= PRESSED;
                        r_db_cnt   <= '0;
                        r_hold_cnt <= '0;
                        key_press  <= 1'b1;
                        key_level  <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!w_sync_pressed) begin
                        // hold_cnt is frozen so a rejected release bounce
                        // resumes the hold rather than restarting it.
                        r_state  <= RELEASE_WAIT;
                        r_db_cnt <= '0;
                    end else if (r_hold_cnt != c_HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                        // Saturation guarantees this fires at most once per press.
                        if (r_hold_cnt == c_HOLD_PRE) begin
                            key_long <= 1'b1;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    if (w_sync_pressed) begin
                        r_state  <= PRESSED;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state     <= IDLE;
                        r_db_cnt    <= '0;
                        r_hold_cnt  <= '0;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_db_cnt <= '0;
                end
            endcase
        end
    end

endmodule : key_debounce
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : key_conditioner
// Purpose : Conditions NUM_KEYS raw active-low push-buttons for the stopwatch
//           controller; one independent key_debounce channel per key.
// Ports   : clk         in  system clock
//           reset       in  synchronous active-high reset
//           key_n       in  [NUM_KEYS] raw buttons, 0 = pressed
//           key_level   out [NUM_KEYS] debounced level
//           key_press   out [NUM_KEYS] 1-cycle debounced press pulse
//           key_release out [NUM_KEYS] 1-cycle debounced release pulse
//           key_long    out [NUM_KEYS] 1-cycle long-press pulse
// Revision: 1.0 - initial release
// ============================================================================
module key_conditioner
    import stopwatch_pkg::*;
#(
    parameter int NUM_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
                .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
            ) u_key_debounce (
                .clk         (clk),
                .reset       (reset),
                .key_n       (key_n[i]),
                .key_level   (key_level[i]),
                .key_press   (key_press[i]),
                .key_release (key_release[i]),
                .key_long    (key_long[i])
            );
        end
    endgenerate

endmodule : key_conditioner
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_conditioner
// Purpose : Directed self-checking bench for key_conditioner with
//           DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_KEYS=2.
//           Edge numbering restarts at 1 after each test's reset release;
//           outputs are sampled on the falling edge following edge e.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key_n;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] key_long;

    int         n_vec = 0;
    int         n_err = 0;
    int         e     = 0;
    int         nx;
    logic [7:0] x;

    key_conditioner #(
        .NUM_KEYS          (2),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    // Observed vector packing: {press[1:0], release[1:0], long[1:0], level[1:0]}
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got {prs,rel,lng,lvl}=%b, expected %b",
                     tag, e, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    task automatic start_test(input string tag);
        reset = 1'b1;
        key_n = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        e = 0;
        chk({tag, "_reset"}, {key_press, key_release, key_long, key_level}, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        key_n = 2'b11;

        // Clean press on key 0 from edge 10: press after edge 16, level held.
        start_test("clean");
        for (int i = 0; i < 30; i++) begin
            nx    = e + 1;
            key_n = (nx >= 10) ? 2'b10 : 2'b11;
            tick;
            x = {(e == 16) ? 2'b01 : 2'b00, 2'b00, 2'b00, (e >= 16) ? 2'b01 : 2'b00};
            chk("clean_press", {key_press, key_release, key_long, key_level}, x);
        end

        // Press bounce: 3 low / 1 high for 40 cycles, nothing may come out.
        start_test("bounce");
        for (int i = 0; i < 70; i++) begin
            nx       = e + 1;
            key_n    = 2'b11;
            key_n[0] = !((nx >= 10) && (nx < 50) && (((nx - 10) % 4) != 3));
            tick;
            chk("press_bounce", {key_press, key_release, key_long, key_level}, 8'h00);
        end

        // Long press: held edges 10..49, press@16, long@36, release@56.
        start_test("long");
        for (int i = 0; i < 75; i++) begin
            nx    = e + 1;
            key_n = ((nx >= 10) && (nx < 50)) ? 2'b10 : 2'b11;
            tick;
            x = {(e == 16) ? 2'b01 : 2'b00,
                 (e == 56) ? 2'b01 : 2'b00,
                 (e == 36) ? 2'b01 : 2'b00,
                 ((e >= 16) && (e < 56)) ? 2'b01 : 2'b00};
            chk("long_press", {key_press, key_release, key_long, key_level}, x);
        end

        // Release with bounce: high at 40, low 42..43, high from 44 -> release@50.
        start_test("relbounce");
        for (int i = 0; i < 65; i++) begin
            nx       = e + 1;
            key_n    = 2'b11;
            key_n[0] = !(((nx >= 10) && (nx < 40)) || (nx == 42) || (nx == 43));
            tick;
            x = {(e == 16) ? 2'b01 : 2'b00,
                 (e == 50) ? 2'b01 : 2'b00,
                 (e == 36) ? 2'b01 : 2'b00,
                 ((e >= 16) && (e < 50)) ? 2'b01 : 2'b00};
            chk("release_bounce", {key_press, key_release, key_long, key_level}, x);
        end

        // Reset at edge 13 mid-debounce, key held: re-detected, press@20.
        start_test("midreset");
        for (int i = 0; i < 30; i++) begin
            nx    = e + 1;
            key_n = (nx >= 10) ? 2'b10 : 2'b11;
            reset = (nx == 13);
            tick;
            x = {(e == 20) ? 2'b01 : 2'b00, 2'b00, 2'b00, (e >= 20) ? 2'b01 : 2'b00};
            chk("reset_mid_debounce", {key_press, key_release, key_long, key_level}, x);
        end
        reset = 1'b0;

        // Both keys at edge 10; key 1 released at 30 -> release[1]@36, long[0]@36.
        start_test("simul");
        for (int i = 0; i < 45; i++) begin
            nx       = e + 1;
            key_n[0] = !(nx >= 10);
            key_n[1] = !((nx >= 10) && (nx < 30));
            tick;
            x = {(e == 16) ? 2'b11 : 2'b00,
                 (e == 36) ? 2'b10 : 2'b00,
                 (e == 36) ? 2'b01 : 2'b00,
                 (e < 16) ? 2'b00 : ((e < 36) ? 2'b11 : 2'b01)};
            chk("simultaneous", {key_press, key_release, key_long, key_level}, x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_key_conditioner
`default_nettype wire
